pdm_cic_tdm: RTL and testbench



---
 rtl/pdm_pkg.sv | 18 +
 rtl/pdm_cic_integrator.sv | 37 +++
 rtl/pdm_cic_tdm.sv | 139 +++++++++++++
 tb/tb_pdm_cic_tdm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared types and width helpers for the multichannel PDM CIC decimator.
package pdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } comb_state_t;

  // Full-precision CIC register width: ORDER*log2(DECIM) bits of growth plus sign/headroom.
  function automatic int cic_width(input int order, input int decim);
    return order * $clog2(decim) + 2;
  endfunction

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pdm_cic_integrator.sv
// One channel's cascaded integrator chain; acc_next is the last stage's value after the current update.
module pdm_cic_integrator #(
  parameter int ORDER = 4,
  parameter int W     = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb,
  input  logic                pdm_bit,
  output logic signed [W-1:0] acc_next
);

  logic signed [W-1:0] integ [ORDER];
  logic signed [W-1:0] nxt   [ORDER];
  logic signed [W-1:0] pdm_val;

  assign pdm_val = pdm_bit ? W'(1) : '1;

  // Each stage adds the previous stage's pre-update value; wrap-around is intentional.
  always_comb begin
    nxt[0] = integ[0] + pdm_val;
    for (int i = 1; i < ORDER; i++) begin
      nxt[i] = integ[i] + integ[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) integ[i] <= '0;
    end else if (stb) begin
      for (int i = 0; i < ORDER; i++) integ[i] <= nxt[i];
    end
  end

  assign acc_next = nxt[ORDER-1];

endmodule

// File: rtl/pdm_cic_tdm.sv
// Multichannel PDM-to-PCM CIC decimator: per-channel integrators, one shared time-multiplexed comb.
// Optional PDM_CIC_ROUND_EN: round-half-up before the output shift, saturating at the positive limit.
//   state | meaning
//   IDLE  | waiting for the next frame snapshot
//   RUN   | combing and emitting channel ch of the current snapshot
module pdm_cic_tdm
  import pdm_pkg::*;
#(
  parameter int CHANNELS = 20,
  parameter int ORDER    = 4,
  parameter int DECIM    = 16,
  parameter int OUT_W    = 16,
  localparam int W       = cic_width(ORDER, DECIM),
  localparam int CHW     = ch_width(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pdm_stb,
  input  logic [CHANNELS-1:0]     pdm_bits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CHW-1:0]          out_ch,
  output logic                    out_last,
  output logic                    overrun
);

  localparam int DW = $clog2(DECIM);
  localparam int SH = W - OUT_W;

  logic signed [W-1:0] acc_next [CHANNELS];
  logic signed [W-1:0] snap     [CHANNELS];
  logic signed [W-1:0] dly      [CHANNELS][ORDER];
  logic signed [W-1:0] comb_x   [ORDER];
  logic signed [W-1:0] comb_y;
  logic signed [OUT_W-1:0] scaled;
  logic [DW-1:0]  dec_cnt;
  logic [CHW-1:0] ch;
  comb_state_t    state, state_nxt;
  logic           take, load, ch_end;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_int
    pdm_cic_integrator #(.ORDER(ORDER), .W(W)) u_int (
      .clk      (clk),
      .rst      (rst),
      .stb      (pdm_stb),
      .pdm_bit  (pdm_bits[g]),
      .acc_next (acc_next[g])
    );
  end

  assign take   = pdm_stb && (dec_cnt == DW'(DECIM - 1));
  assign ch_end = (ch == CHW'(CHANNELS - 1));

  always_ff @(posedge clk) begin
    if (rst) dec_cnt <= '0;
    else if (pdm_stb) dec_cnt <= dec_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (take) state_nxt = RUN;
      RUN: begin
        load = !out_valid || out_ready;
        if (load && ch_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // comb_x[s] is stage s's input, which becomes that stage's delay value on load.
  always_comb begin
    logic signed [W-1:0] x;
    x = snap[ch];
    for (int s = 0; s < ORDER; s++) begin
      comb_x[s] = x;
      x = x - dly[ch][s];
    end
    comb_y = x;
  end

`ifdef PDM_CIC_ROUND_EN
  localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [W:0] RND = (W+1)'((SH > 0) ? 2**RND_SH : 0);
  localparam logic signed [W:0] SAT = (W+1)'(2**(OUT_W-1) - 1);
  logic signed [W:0] rnd_sum, rnd_shr;

  always_comb begin
    rnd_sum = $signed({comb_y[W-1], comb_y}) + RND;
    rnd_shr = rnd_sum >>> SH;
    scaled  = (rnd_shr > SAT) ? SAT[OUT_W-1:0] : rnd_shr[OUT_W-1:0];
  end
`else
  assign scaled = OUT_W'(comb_y >>> SH);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        snap[c] <= '0;
        for (int s = 0; s < ORDER; s++) dly[c][s] <= '0;
      end
    end else begin
      // A frame arriving while the previous one is still draining is dropped outright.
      if (take) begin
        if (state == IDLE) begin
          for (int c = 0; c < CHANNELS; c++) snap[c] <= acc_next[c];
          ch <= '0;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (load) begin
        for (int s = 0; s < ORDER; s++) dly[ch][s] <= comb_x[s];
        out_data  <= scaled;
        out_ch    <= ch;
        out_last  <= ch_end;
        out_valid <= 1'b1;
        ch        <= ch_end ? '0 : ch + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_tdm.sv
// Directed self-checking bench for pdm_cic_tdm at default parameters.
module tb_pdm_cic_tdm;

  localparam int CH = 20;
  localparam int POS = 16384;
  localparam int NEG = -16384;

  typedef enum int {M_ZERO, M_ONE, M_ALT} mode_t;
  typedef struct {
    mode_t base;
    int    sel_ch;
    mode_t sel;
    int    exp_sel;
    int    exp_other;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               pdm_stb;
  logic [CH-1:0]      pdm_bits;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [4:0]         out_ch;
  logic               out_last;
  logic               overrun;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    stb_period = 4;
  int    stb_cnt = 0;
  logic  alt_phase = 1'b0;
  mode_t base_mode = M_ONE;
  mode_t sel_mode = M_ONE;
  int    sel_ch = 0;

  always #5 clk = ~clk;

  pdm_cic_tdm dut (
    .clk       (clk),
    .rst       (rst),
    .pdm_stb   (pdm_stb),
    .pdm_bits  (pdm_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic mode_bit(input mode_t m);
    case (m)
      M_ZERO:  return 1'b0;
      M_ONE:   return 1'b1;
      default: return alt_phase;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge, then inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pdm_stb = (stb_period == 1) || (cyc % stb_period == 0);
    if (pdm_stb) begin
      alt_phase = ~alt_phase;
      stb_cnt++;
    end
    for (int i = 0; i < CH; i++) pdm_bits[i] = (i == sel_ch) ? mode_bit(sel_mode) : mode_bit(base_mode);
  endtask

  task automatic next_xfer(output logic ok, output logic signed [15:0] d,
                           output logic [4:0] c, output logic l);
    ok = 1'b0;
    d = '0;
    c = '0;
    l = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (out_valid && out_ready) begin
        d = out_data;
        c = out_ch;
        l = out_last;
        ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic wait_frames(input string tag, input int n);
    logic ok, l;
    logic signed [15:0] d;
    logic [4:0] c;
    int seen = 0;
    while (seen < n) begin
      next_xfer(ok, d, c, l);
      if (!ok) begin
        check({tag, " frame wait"}, 0, 1);
        break;
      end
      if (l) seen++;
    end
  endtask

  task automatic capture_frame(input string tag, input int first, input int sch,
                               input int exp_sel, input int exp_other);
    logic ok, l;
    logic signed [15:0] d;
    logic [4:0] c;
    for (int i = first; i < CH; i++) begin
      next_xfer(ok, d, c, l);
      check($sformatf("%s xfer%0d seen", tag, i), int'(ok), 1);
      if (!ok) break;
      check($sformatf("%s ch%0d index", tag, i), int'(c), i);
      check($sformatf("%s ch%0d data", tag, i), int'(d), (i == sch) ? exp_sel : exp_other);
      check($sformatf("%s ch%0d last", tag, i), int'(l), (i == CH - 1) ? 1 : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check({tag, " out_data"}, int'(out_data), 0);
    check({tag, " out_ch"}, int'(out_ch), 0);
    check({tag, " out_last"}, int'(out_last), 0);
    check({tag, " overrun"}, int'(overrun), 0);
  endtask

  vec_t vecs [6];

  initial begin
    int guard;
    int drops;

    vecs[0] = '{base: M_ONE,  sel_ch: 0,  sel: M_ONE,  exp_sel: POS, exp_other: POS};
    vecs[1] = '{base: M_ZERO, sel_ch: 0,  sel: M_ZERO, exp_sel: NEG, exp_other: NEG};
    vecs[2] = '{base: M_ALT,  sel_ch: 0,  sel: M_ALT,  exp_sel: 0,   exp_other: 0};
    vecs[3] = '{base: M_ZERO, sel_ch: 7,  sel: M_ONE,  exp_sel: POS, exp_other: NEG};
    vecs[4] = '{base: M_ONE,  sel_ch: 19, sel: M_ZERO, exp_sel: NEG, exp_other: POS};
    vecs[5] = '{base: M_ALT,  sel_ch: 3,  sel: M_ONE,  exp_sel: POS, exp_other: 0};

    rst = 1'b1;
    pdm_stb = 1'b0;
    pdm_bits = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    stb_cnt = pdm_stb ? 1 : 0;

    // First decimating strobe is the 16th after reset: valid exactly two cycles later.
    guard = 0;
    while (!(stb_cnt == 16 && pdm_stb) && guard < 200) begin
      tick();
      guard++;
    end
    check("latency reach 16th strobe", int'(guard < 200), 1);
    tick();
    check("latency N+1 out_valid", int'(out_valid), 0);
    tick();
    check("latency N+2 out_valid", int'(out_valid), 1);
    check("latency N+2 out_ch", int'(out_ch), 0);

    for (int v = 0; v < 6; v++) begin
      base_mode = vecs[v].base;
      sel_mode  = vecs[v].sel;
      sel_ch    = vecs[v].sel_ch;
      wait_frames($sformatf("vec%0d", v), 6);
      capture_frame($sformatf("vec%0d", v), 0, vecs[v].sel_ch, vecs[v].exp_sel, vecs[v].exp_other);
    end

    // Backpressure mid-frame: the held word must not change and the frame must finish intact.
    base_mode = M_ONE;
    sel_mode  = M_ONE;
    sel_ch    = 0;
    wait_frames("stall", 6);
    guard = 0;
    while (!(out_valid && out_ch == 5) && guard < 400) begin
      tick();
      guard++;
    end
    check("stall reach ch5", int'(guard < 400), 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall cyc%0d out_valid", k), int'(out_valid), 1);
      check($sformatf("stall cyc%0d out_ch", k), int'(out_ch), 5);
      check($sformatf("stall cyc%0d out_data", k), int'(out_data), POS);
    end
    out_ready = 1'b1;
    capture_frame("stall", 5, 0, POS, POS);
    check("stall overrun", int'(overrun), 0);

    // Reset while channel 10 is on the output.
    guard = 0;
    while (!(out_valid && out_ch == 10) && guard < 400) begin
      tick();
      guard++;
    end
    check("midrst reach ch10", int'(guard < 400), 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_frames("postrst", 6);
    capture_frame("postrst", 0, 0, POS, POS);

    // Strobe every cycle: 16-cycle frames cannot drain 20 channels.
    stb_period = 1;
    guard = 0;
    while (!overrun && guard < 500) begin
      tick();
      guard++;
    end
    check("overrun set", int'(overrun), 1);
    drops = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!overrun) drops++;
    end
    check("overrun sticky", drops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
